// File: rtl/fwd_ctrl.sv
// Operand-forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks EX/MEM/WB destination info and drives the ALU operand mux selects and the stall line.
module fwd_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             ex_valid;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic             ex_uses_rt;

    logic             mem_valid;
    logic             mem_reg_write;
    logic [REG_W-1:0] mem_rd;

    logic             wb_valid;
    logic             wb_reg_write;
    logic [REG_W-1:0] wb_rd;

    logic             capture;
    logic             mem_hit_a;
    logic             wb_hit_a;
    logic             mem_hit_b;
    logic             wb_hit_b;
    logic             load_hit;

    // Register 0 is hardwired, so a stage writing it never produces a usable value.
    function automatic logic stage_writes(
        input logic             valid,
        input logic             reg_write,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] r
    );
        return valid && reg_write && (rd == r) && (r != '0);
    endfunction

    always_comb begin
        mem_hit_a = stage_writes(mem_valid, mem_reg_write, mem_rd, ex_rs);
        wb_hit_a  = stage_writes(wb_valid,  wb_reg_write,  wb_rd,  ex_rs);
        mem_hit_b = stage_writes(mem_valid, mem_reg_write, mem_rd, ex_rt);
        wb_hit_b  = stage_writes(wb_valid,  wb_reg_write,  wb_rd,  ex_rt);
    end

    // MEM is checked first because it holds the youngest copy of the register.
    always_comb begin
        fwd_a_sel = SEL_RF;
        fwd_b_sel = SEL_RF;
        if (ex_valid) begin
            if (mem_hit_a) begin
                fwd_a_sel = SEL_MEM;
            end else if (wb_hit_a) begin
                fwd_a_sel = SEL_WB;
            end
            if (ex_uses_rt) begin
                if (mem_hit_b) begin
                    fwd_b_sel = SEL_MEM;
                end else if (wb_hit_b) begin
                    fwd_b_sel = SEL_WB;
                end
            end
        end
    end

    // A load in EX cannot forward until it reaches MEM/WB, so its dependent waits one cycle.
    always_comb begin
        load_hit = (ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt));
        stall    = id_valid && !flush && ex_valid && ex_mem_read &&
                   (ex_rd != '0) && load_hit;
        capture  = id_valid && !stall && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rd        <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_uses_rt   <= 1'b0;
        end else begin
            ex_valid <= capture;
            if (capture) begin
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
                ex_rd        <= id_rd;
                ex_rs        <= id_rs;
                ex_rt        <= id_rt;
                ex_uses_rt   <= id_uses_rt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_rd        <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
        end else begin
            mem_valid     <= ex_valid;
            mem_reg_write <= ex_reg_write;
            mem_rd        <= ex_rd;
            wb_valid      <= mem_valid;
            wb_reg_write  <= mem_reg_write;
            wb_rd         <= mem_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: directed pipeline sequences push expected outputs,
// a negedge monitor pops and compares them against a 16-bit and a 2-bit counter instance.
module tb_fwd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;

    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        stall;
    logic [15:0] stall_count;

    logic [1:0]  fwd_a_sel2;
    logic [1:0]  fwd_b_sel2;
    logic        stall2;
    logic [1:0]  stall_count2;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       s;
        int         cnt;
        int         cnt2;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass;
    int   n_total;
    int   model_stalls;

    fwd_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_count(stall_count)
    );

    fwd_ctrl #(.REG_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .fwd_a_sel(fwd_a_sel2),
        .fwd_b_sel(fwd_b_sel2), .stall(stall2), .stall_count(stall_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one ID instruction just after the edge and records what the outputs must be this cycle.
    task automatic applyStimulus(
        input logic v, input int rs, input int rt, input logic ut, input int rd,
        input logic rw, input logic mr, input logic fl,
        input int ea, input int eb, input logic es, input logic rst, input string name
    );
        exp_t e;
        @(posedge clk);
        #1;
        id_valid     = v;
        id_rs        = 5'(rs);
        id_rt        = 5'(rt);
        id_uses_rt   = ut;
        id_rd        = 5'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
        if (rst) begin
            rst_n        = 1'b0;
            model_stalls = 0;
        end
        e.a    = 2'(ea);
        e.b    = 2'(eb);
        e.s    = es;
        e.cnt  = model_stalls;
        e.cnt2 = (model_stalls > 3) ? 3 : model_stalls;
        e.name = name;
        exp_q.push_back(e);
        if (es) model_stalls++;
    endtask

    task automatic nopCycle(input int ea, input int eb, input string name);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, ea, eb, 0, 0, name);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput({e.name, " fwd_a"},  int'(fwd_a_sel),    int'(e.a));
            checkOutput({e.name, " fwd_b"},  int'(fwd_b_sel),    int'(e.b));
            checkOutput({e.name, " stall"},  int'(stall),        int'(e.s));
            checkOutput({e.name, " count"},  int'(stall_count),  e.cnt);
            checkOutput({e.name, " fwd_a2"}, int'(fwd_a_sel2),   int'(e.a));
            checkOutput({e.name, " fwd_b2"}, int'(fwd_b_sel2),   int'(e.b));
            checkOutput({e.name, " stall2"}, int'(stall2),       int'(e.s));
            checkOutput({e.name, " count2"}, int'(stall_count2), e.cnt2);
        end
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        model_stalls = 0;
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // add $3 ; sub $5,$3,$4
        applyStimulus(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, "exmem add");
        applyStimulus(1, 3, 4, 1, 5, 1, 0, 0, 0, 0, 0, 0, "exmem sub_id");
        nopCycle(1, 0, "exmem sub_ex");
        nopCycle(0, 0, "exmem drain1");
        nopCycle(0, 0, "exmem drain2");

        // add $3 ; nop ; or $6,$7,$3
        applyStimulus(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, "memwb add");
        nopCycle(0, 0, "memwb nop");
        applyStimulus(1, 7, 3, 1, 6, 1, 0, 0, 0, 0, 0, 0, "memwb or_id");
        nopCycle(0, 2, "memwb or_ex");
        nopCycle(0, 0, "memwb drain1");
        nopCycle(0, 0, "memwb drain2");

        // add $3 ; add $3 ; and $8,$3,$3
        applyStimulus(1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, "prio add1");
        applyStimulus(1, 4, 5, 1, 3, 1, 0, 0, 0, 0, 0, 0, "prio add2");
        applyStimulus(1, 3, 3, 1, 8, 1, 0, 0, 0, 0, 0, 0, "prio and_id");
        nopCycle(1, 1, "prio and_ex");
        nopCycle(0, 0, "prio drain1");
        nopCycle(0, 0, "prio drain2");

        // lw $2 ; add $4,$2,$1 (held in ID for the stall cycle)
        applyStimulus(1, 1, 2, 0, 2, 1, 1, 0, 0, 0, 0, 0, "lu lw");
        applyStimulus(1, 2, 1, 1, 4, 1, 0, 0, 0, 0, 1, 0, "lu stall");
        applyStimulus(1, 2, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, "lu bubble");
        nopCycle(2, 0, "lu add_ex");
        nopCycle(0, 0, "lu drain1");
        nopCycle(0, 0, "lu drain2");

        // add $0 ; sub $5,$0,$0
        applyStimulus(1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, "r0 add");
        applyStimulus(1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, "r0 sub_id");
        nopCycle(0, 0, "r0 sub_ex");
        nopCycle(0, 0, "r0 drain");

        // lw $9 ; addi $10,$11 with rt=9 not read
        applyStimulus(1, 1, 9, 0, 9, 1, 1, 0, 0, 0, 0, 0, "nort lw");
        applyStimulus(1, 11, 9, 0, 10, 1, 0, 0, 0, 0, 0, 0, "nort addi_id");
        nopCycle(0, 0, "nort addi_ex");
        nopCycle(0, 0, "nort drain");

        // lw $2 ; add $4,$2,$1 flushed in ID
        applyStimulus(1, 1, 2, 0, 2, 1, 1, 0, 0, 0, 0, 0, "flush lw");
        applyStimulus(1, 2, 1, 1, 4, 1, 0, 1, 0, 0, 0, 0, "flush add");
        nopCycle(0, 0, "flush bubble");
        nopCycle(0, 0, "flush drain");

        // five load-use pairs in a row; 2-bit counter must stop at 3
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 1, 2, 0, 2, 1, 1, 0, (k == 0) ? 0 : 2, 0, 0, 0, "sat lw");
            applyStimulus(1, 2, 1, 1, 4, 1, 0, 0, 0, 0, 1, 0, "sat stall");
            applyStimulus(1, 2, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, "sat bubble");
        end
        nopCycle(2, 0, "sat add_ex");
        nopCycle(0, 0, "sat drain1");
        nopCycle(0, 0, "sat drain2");

        // reset while a load sits in EX with its dependent in ID
        applyStimulus(1, 1, 2, 0, 2, 1, 1, 0, 0, 0, 0, 0, "rst lw");
        applyStimulus(1, 2, 1, 1, 4, 1, 0, 0, 0, 0, 0, 1, "rst midstall");
        @(negedge clk);
        #1 rst_n = 1'b1;

        applyStimulus(1, 1, 2, 0, 2, 1, 1, 0, 0, 0, 0, 0, "post lw");
        applyStimulus(1, 2, 1, 1, 4, 1, 0, 0, 0, 0, 1, 0, "post stall");
        applyStimulus(1, 2, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, "post bubble");
        nopCycle(2, 0, "post add_ex");
        nopCycle(0, 0, "post drain");

        @(negedge clk);
        #1;
        checkOutput("scoreboard empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
